// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: RV32/RV64 OP and OP-IMM execute unit with iterative M-ext.
// Base ops finish in one cycle; MUL/DIV iterate one bit per cycle.
module alu_mdu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_M    = 7'b0000001;
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [SHW-1:0]  LAST = SHW'(XLEN - 1);

  state_t            state;
  logic [XLEN-1:0]   hi, lo, dv;
  logic [SHW-1:0]    cnt;
  logic              neg_q, neg_r, sel;

  logic              is_op, is_imm, is_m, d_sgn, d_ovf;
  logic              go_uns, go_bas, go_mul, go_dsp, go_div;
  logic              sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   sra_res, base_res, dsp_res;
  logic [XLEN-1:0]   addend, nxt_hi, nxt_lo, quo, rem, fin;
  logic [XLEN:0]     mul_sum, r_sh, r_df;
  logic [2*XLEN-1:0] prod, prod_s;

  assign in_ready = state == S_IDLE;
  assign busy     = state != S_IDLE;

  always_comb begin
    is_op  = opcode == OPC_OP;
    is_imm = opcode == OPC_IMM;
    is_m   = funct7 == F7_M;
    d_sgn  = !funct3[0];
    d_ovf  = d_sgn && op_a == MIN && op_b == ONES;
    go_uns = !(is_op || is_imm) || (is_imm && is_m);
    go_bas = (is_op || is_imm) && !is_m;
    go_mul = is_op && is_m && !funct3[2];
    go_dsp = is_op && is_m && funct3[2] && (op_b == '0 || d_ovf);
    go_div = is_op && is_m && funct3[2] && !(op_b == '0 || d_ovf);
    sgn_a  = funct3[2] ? d_sgn : funct3[1:0] != 2'b11;
    sgn_b  = funct3[2] ? d_sgn : !funct3[1];
    neg_a  = sgn_a && op_a[XLEN-1];
    neg_b  = sgn_b && op_b[XLEN-1];
    mag_a  = neg_a ? -op_a : op_a;
    mag_b  = neg_b ? -op_b : op_b;
  end

  always_comb begin
    shamt   = op_b[SHW-1:0];
    sra_res = $signed(op_a) >>> shamt;
    unique case (funct3)
      3'b000: base_res = (is_op && funct7[5]) ? op_a - op_b
                                              : op_a + op_b;
      3'b001: base_res = op_a << shamt;
      3'b010: base_res = XLEN'($signed(op_a) < $signed(op_b));
      3'b011: base_res = XLEN'(op_a < op_b);
      3'b100: base_res = op_a ^ op_b;
      3'b101: base_res = funct7[5] ? sra_res : op_a >> shamt;
      3'b110: base_res = op_a | op_b;
      3'b111: base_res = op_a & op_b;
    endcase
    if (op_b == '0)
      dsp_res = funct3[1] ? op_a : ONES;
    else
      dsp_res = funct3[1] ? '0 : MIN;
  end

  // One iteration: shift-add for MUL, restoring subtract for DIV.
  always_comb begin
    addend  = lo[0] ? dv : '0;
    mul_sum = {1'b0, hi} + {1'b0, addend};
    r_sh    = {hi, lo[XLEN-1]};
    r_df    = r_sh - {1'b0, dv};
    if (state == S_MUL) begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], lo[XLEN-1:1]};
    end else begin
      nxt_hi = r_df[XLEN] ? r_sh[XLEN-1:0] : r_df[XLEN-1:0];
      nxt_lo = {lo[XLEN-2:0], !r_df[XLEN]};
    end
    prod   = {nxt_hi, nxt_lo};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -nxt_lo : nxt_lo;
    rem    = neg_r ? -nxt_hi : nxt_hi;
    if (state == S_MUL)
      fin = sel ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    else
      fin = sel ? rem : quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      lo        <= '0;
      dv        <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      sel       <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) begin
          cnt <= '0;
          unique case (1'b1)
            go_uns: begin
              result    <= '0;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
            go_bas: begin
              result    <= base_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
            go_dsp: begin
              result    <= dsp_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
            go_mul, go_div: begin
              hi    <= '0;
              lo    <= funct3[2] ? mag_a : mag_b;
              dv    <= funct3[2] ? mag_b : mag_a;
              neg_q <= neg_a ^ neg_b;
              neg_r <= neg_a;
              sel   <= funct3[2] ? funct3[1]
                                 : funct3[1:0] != 2'b00;
              state <= go_mul ? S_MUL : S_DIV;
            end
          endcase
        end
        S_MUL, S_DIV: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt + SHW'(1);
          if (cnt == LAST) begin
            result    <= fin;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: scoreboard bench for alu_mdu_seq, XLEN=32 and XLEN=64.
// Expected results come from a plain-arithmetic reference model.
module tb_alu_mdu_seq;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] F7M = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0, result;
  logic        flush = 1'b0, out_valid, out_ready = 1'b0, busy;

  logic        v64 = 1'b0, rdy64, ov64, busy64;
  logic [6:0]  opc64 = '0, f7_64 = '0;
  logic [2:0]  f3_64 = '0;
  logic [63:0] a64 = '0, b64 = '0, res64;

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(32), .SHW(5)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  alu_mdu_seq #(.XLEN(64), .SHW(6)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v64), .in_ready(rdy64),
    .opcode(opc64), .funct3(f3_64), .funct7(f7_64),
    .op_a(a64), .op_b(b64), .flush(1'b0),
    .out_valid(ov64), .out_ready(1'b1),
    .result(res64), .busy(busy64)
  );

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int total = 0, bad = 0, cyc = 0, n_out = 0, bp_hold = 0;
  logic        held = 1'b0;
  logic [31:0] hold_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Reference model: RISC-V semantics via wide signed arithmetic.
  function automatic logic [63:0] ref_res(input int w,
      input logic [6:0] opc, input logic [2:0] f3,
      input logic [6:0] f7, input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] m, a, b;
    logic signed [129:0] sa, sb_, ua, ub, p;
    int sh;
    m  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    a  = ai & m;
    b  = bi & m;
    ua = {66'd0, a};
    ub = {66'd0, b};
    sa  = (w == 32) ? {{98{a[31]}}, a[31:0]} : {{66{a[63]}}, a};
    sb_ = (w == 32) ? {{98{b[31]}}, b[31:0]} : {{66{b[63]}}, b};
    sh = (w == 32) ? int'(b[4:0]) : int'(b[5:0]);
    if (opc != OP && opc != IMM) return 64'd0;
    if (f7 == F7M) begin
      if (opc == IMM) return 64'd0;
      case (f3)
        3'd0: begin p = sa * sb_; return 64'(p) & m; end
        3'd1: begin p = sa * sb_; return 64'(p >>> w) & m; end
        3'd2: begin p = sa * ub;  return 64'(p >>> w) & m; end
        3'd3: begin p = ua * ub;  return 64'(p >>> w) & m; end
        default: begin
          if (b == 64'd0) return f3[1] ? a : m;
          case (f3)
            3'd4: p = sa / sb_;
            3'd5: p = ua / ub;
            3'd6: p = sa % sb_;
            default: p = ua % ub;
          endcase
          return 64'(p) & m;
        end
      endcase
    end
    case (f3)
      3'd0: return ((opc == OP && f7[5]) ? a - b : a + b) & m;
      3'd1: return (a << sh) & m;
      3'd2: return {63'd0, sa < sb_};
      3'd3: return {63'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 64'(sa >>> sh) & m : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_lat(input int w,
      input logic [6:0] opc, input logic [2:0] f3,
      input logic [6:0] f7, input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] m, mn;
    m  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    mn = 64'd1 << (w - 1);
    if (opc != OP || f7 != F7M) return 1;
    if (!f3[2]) return w + 1;
    if ((bi & m) == 64'd0) return 1;
    if (!f3[0] && (ai & m) == mn && (bi & m) == m) return 1;
    return w + 1;
  endfunction

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    int g;
    g = 0;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      tmo("issue");
      return;
    end
    e.res = ref_res(32, opc, f3, f7, {32'd0, a}, {32'd0, b});
    e.lat = ref_lat(32, opc, f3, f7, {32'd0, a}, {32'd0, b});
    e.acc = cyc + 1;
    opcode = opc; funct3 = f3; funct7 = f7;
    op_a = a; op_b = b; in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    opcode = 7'($urandom()); funct3 = 3'($urandom());
    funct7 = 7'($urandom());
    op_a = $urandom(); op_b = $urandom();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) tmo("drain");
  endtask

  // Monitor: pops on each new result, checks hold while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (!held) begin
          n_out++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %h want none", result);
          end else begin
            me = sb.pop_front();
            chk("result", {32'd0, result}, me.res);
            chk("latency", 64'(cyc - me.acc + 1), 64'(me.lat));
          end
          held = 1'b1;
          hold_val = result;
        end else begin
          chk("hold_result", {32'd0, result}, {32'd0, hold_val});
          chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        if (bp_hold > 0) begin
          bp_hold--;
          out_ready = 1'b0;
        end else begin
          out_ready = $urandom_range(0, 3) != 0;
        end
        if (out_ready) held = 1'b0;
      end else begin
        out_ready = 1'(($urandom_range(0, 1)));
      end
    end
  end

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [6:0] rnd_opc();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return OP;
    if (r < 9) return IMM;
    return 7'($urandom());
  endfunction

  function automatic logic [6:0] rnd_f7();
    case ($urandom_range(0, 5))
      0, 1: return 7'h00;
      2: return 7'h20;
      3, 4: return F7M;
      default: return 7'($urandom());
    endcase
  endfunction

  task automatic run64(input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [63:0] a,
                       input logic [63:0] b);
    logic [63:0] er;
    int el, n;
    er = ref_res(64, opc, f3, f7, a, b);
    el = ref_lat(64, opc, f3, f7, a, b);
    n = 0;
    while (!rdy64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    opc64 = opc; f3_64 = f3; f7_64 = f7; a64 = a; b64 = b;
    v64 = 1'b1;
    @(negedge clk);
    v64 = 1'b0;
    n = 1;
    while (!ov64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ov64) begin
      tmo("run64");
    end else begin
      chk("result64", res64, er);
      chk("latency64", 64'(n), 64'(el));
    end
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] r0;
  int n0;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);

    issue(OP, 3'd0, 7'h00, 32'h7FFF_FFFF, 32'd1);
    issue(OP, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    issue(IMM, 3'd5, 7'h20, 32'h8000_0000, 32'h0000_0404);
    issue(OP, 3'd3, 7'h00, 32'd1, 32'hFFFF_FFFF);
    issue(OP, 3'd0, 7'h20, 32'd5, 32'd9);
    issue(IMM, 3'd0, 7'h20, 32'd5, 32'd9);
    issue(OP, 3'd1, F7M, 32'hFFFF_FFFF, 32'd2);
    issue(OP, 3'd3, F7M, 32'hFFFF_FFFF, 32'd2);
    issue(OP, 3'd2, F7M, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(OP, 3'd4, F7M, 32'd7, 32'd0);
    issue(OP, 3'd7, F7M, 32'd7, 32'd0);
    issue(OP, 3'd6, F7M, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP, 3'd4, F7M, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP, 3'd4, F7M, 32'hFFFF_FFF9, 32'd2);
    issue(OP, 3'd6, F7M, 32'hFFFF_FFF9, 32'd2);
    issue(IMM, 3'd0, F7M, 32'd3, 32'd4);
    issue(7'h33 ^ 7'h40, 3'd0, 7'h00, 32'd3, 32'd4);
    drain();

    bp_hold = 5;
    issue(OP, 3'd6, 7'h00, 32'h0F0F_0000, 32'h0000_00F0);
    drain();

    n0 = n_out;
    opcode = OP; funct3 = 3'd0; funct7 = 7'h00;
    op_a = 32'd5; op_b = 32'd6;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", {63'd0, busy}, 64'd0);
    chk("flush_idle_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(negedge clk);
    chk("flush_idle_no_out", 64'(n_out), 64'(n0));

    r0 = result;
    opcode = OP; funct3 = 3'd4; funct7 = F7M;
    op_a = 32'd100; op_b = 32'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("div_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (40) @(negedge clk);
    chk("flush_no_out", 64'(n_out), 64'(n0));
    chk("flush_result", {32'd0, result}, {32'd0, r0});

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(rnd_opc(), 3'($urandom()), rnd_f7(), rnd_opnd(), rnd_opnd());
    end
    drain();

    issue(OP, 3'd0, 7'h00, 32'd5, 32'd3);
    drain();
    opcode = OP; funct3 = 3'd3; funct7 = F7M;
    op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);

    run64(OP, 3'd3, F7M, 64'h8000_0000_0000_0000, 64'd4);
    run64(OP, 3'd5, 7'h20, 64'h8000_0000_0000_0000, 64'd36);
    run64(OP, 3'd6, F7M, 64'h8000_0000_0000_0000, '1);
    for (int i = 0; i < 10; i++)
      run64(OP, 3'($urandom()), (i % 2 == 0) ? F7M : 7'h20,
            {$urandom(), $urandom()}, {$urandom(), $urandom()});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
